// File: rtl/xgriscv_defines.sv
// rtl/xgriscv_defines.sv - shared widths and load FSM encoding for the xgriscv data path
package xgriscv_defines;

    localparam int XLEN_DEF      = 32;
    localparam int ADDR_SIZE_DEF = 32;

    // Load sequencer states of the store buffer.
    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_LREQ  = 2'd1,
        LSU_LRESP = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/xgriscv_sbuf_fifo.sv
// rtl/xgriscv_sbuf_fifo.sv - circular FIFO of pending stores with per-entry word-address match
//
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   push, push_*        enqueue {addr, be, wdata}; ignored when full
//   pop                 dequeue head; ignored when empty
//   head_*              oldest entry
//   full, empty, count  occupancy
//   match_word          word address (addr[ADDR_SIZE-1:2]) of a load to compare
//   match               one bit per entry: entry valid and same word
module xgriscv_sbuf_fifo
    import xgriscv_defines::*;
#(
    parameter int DEPTH     = 4,
    parameter int XLEN      = XLEN_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [ADDR_SIZE-1:0] push_addr,
    input  logic [3:0]           push_be,
    input  logic [XLEN-1:0]      push_wdata,
    input  logic                 pop,
    output logic [ADDR_SIZE-1:0] head_addr,
    output logic [3:0]           head_be,
    output logic [XLEN-1:0]      head_wdata,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_W-1:0]     count,
    input  logic [ADDR_SIZE-3:0] match_word,
    output logic [DEPTH-1:0]     match
);

    logic [ADDR_SIZE-1:0] addr_q  [DEPTH];
    logic [3:0]           be_q    [DEPTH];
    logic [XLEN-1:0]      wdata_q [DEPTH];
    logic [DEPTH-1:0]     valid_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_addr  = addr_q[rd_ptr_q];
    assign head_be    = be_q[rd_ptr_q];
    assign head_wdata = wdata_q[rd_ptr_q];

    // Payload needs no reset: an entry is only observed while its valid bit is set.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_q[wr_ptr_q]  <= push_addr;
            be_q[wr_ptr_q]    <= push_be;
            wdata_q[wr_ptr_q] <= push_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
                valid_q[wr_ptr_q] <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
                valid_q[rd_ptr_q] <= 1'b0;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid_q[i] && (addr_q[i][ADDR_SIZE-1:2] == match_word);
        end
    end

endmodule

// File: rtl/xgriscv_store_buffer.sv
// rtl/xgriscv_store_buffer.sv - write buffer between core LSU and memory port with load hazard stall
//
// Ports:
//   clk, reset                   clock, synchronous active-low reset
//   core_req/we/amp/addr/wdata   core data access (store buffered, load forwarded to memory)
//   core_fence                   hold core until the buffer is empty
//   core_rdata, core_stall       load result, core hold
//   mem_req/we/be/addr/wdata     memory request, stable until mem_gnt
//   mem_gnt, mem_rvalid, mem_rdata  memory handshake and read response
//   wbuf_count, wbuf_empty       buffer occupancy
module xgriscv_store_buffer
    import xgriscv_defines::*;
#(
    parameter int DEPTH     = 4,
    parameter int XLEN      = XLEN_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   core_req,
    input  logic                   core_we,
    input  logic [3:0]             core_amp,
    input  logic [ADDR_SIZE-1:0]   core_addr,
    input  logic [XLEN-1:0]        core_wdata,
    input  logic                   core_fence,
    output logic [XLEN-1:0]        core_rdata,
    output logic                   core_stall,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [3:0]             mem_be,
    output logic [ADDR_SIZE-1:0]   mem_addr,
    output logic [XLEN-1:0]        mem_wdata,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  logic [XLEN-1:0]        mem_rdata,
    output logic [$clog2(DEPTH):0] wbuf_count,
    output logic                   wbuf_empty
);

    lsu_state_e state_q, state_d;

    logic                 store_req;
    logic                 load_req;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [DEPTH-1:0]     fifo_match;
    logic [ADDR_SIZE-1:0] head_addr;
    logic [3:0]           head_be;
    logic [XLEN-1:0]      head_wdata;
    logic                 hazard;
    logic                 load_issue;
    logic                 load_done;
    logic                 drain;
    // A write was offered without grant last cycle; it must be re-offered unchanged.
    logic                 wr_hold_q;

    assign store_req = core_req && core_we;
    assign load_req  = core_req && !core_we;
    assign hazard    = |fifo_match;
    assign fifo_push = store_req && !fifo_full;
    assign fifo_pop  = drain && mem_gnt;

    xgriscv_sbuf_fifo #(
        .DEPTH     (DEPTH),
        .XLEN      (XLEN),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_addr  (core_addr),
        .push_be    (core_amp),
        .push_wdata (core_wdata),
        .pop        (fifo_pop),
        .head_addr  (head_addr),
        .head_be    (head_be),
        .head_wdata (head_wdata),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (wbuf_count),
        .match_word (core_addr[ADDR_SIZE-1:2]),
        .match      (fifo_match)
    );

    assign wbuf_empty = fifo_empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= LSU_IDLE;
            wr_hold_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_hold_q <= drain && !mem_gnt;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_issue = 1'b0;
        load_done  = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                // The request is driven already in the IDLE cycle so a granted
                // load skips LREQ and completes in two cycles.
                if (load_req && !hazard && !wr_hold_q) begin
                    load_issue = 1'b1;
                    state_d    = mem_gnt ? LSU_LRESP : LSU_LREQ;
                end
            end
            LSU_LREQ: begin
                load_issue = 1'b1;
                if (mem_gnt) begin
                    state_d = LSU_LRESP;
                end
            end
            LSU_LRESP: begin
                if (mem_rvalid) begin
                    load_done = 1'b1;
                    state_d   = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    assign drain = !load_issue && !fifo_empty;

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (load_issue) begin
            mem_req  = 1'b1;
            mem_addr = core_addr;
            mem_be   = core_amp;
        end else if (drain) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = head_addr;
            mem_be    = head_be;
            mem_wdata = head_wdata;
        end
    end

    assign core_rdata = load_done ? mem_rdata : '0;
    assign core_stall = (store_req && fifo_full)
                      || (load_req && !load_done)
                      || (core_fence && !fifo_empty);

endmodule

// File: doc/xgriscv_store_buffer.md
XGRISCV_STORE_BUFFER -- requirements
Module: xgriscv_store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of pending-store entries; power of two, minimum 2.
REQ-002 Parameter XLEN, default 32, data width; ADDR_SIZE, default 32, address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous and active-low.
REQ-005 core_req  input  1  core requests a data access this cycle.
REQ-006 core_we  input  1  1 = store, 0 = load.
REQ-007 core_amp  input  4  byte enables for the access.
REQ-008 core_addr  input  ADDR_SIZE  byte address.
REQ-009 core_wdata  input  XLEN  store data, already lane-aligned.
REQ-010 core_fence  input  1  core requests that all buffered stores complete.
REQ-011 core_rdata  output  XLEN  load data; valid when the load completes.
REQ-012 core_stall  output  1  core holds its memory stage this cycle.
REQ-013 mem_req, mem_we  output  1 each  memory-port request and its direction.
REQ-014 mem_be  output  4;  mem_addr  output  ADDR_SIZE;  mem_wdata  output  XLEN.
REQ-015 mem_gnt  input  1  memory accepts the request this cycle.
REQ-016 mem_rvalid  input  1;  mem_rdata  input  XLEN  read response, at least one cycle after grant.
REQ-017 wbuf_count  output  log2(DEPTH)+1  occupied entries;  wbuf_empty  output  1.

Function
REQ-018 Stores are accepted into a circular FIFO entry {addr, be, wdata} in the same cycle if count<DEPTH at cycle start; no stall.
REQ-019 Store with count==DEPTH: core_stall=1; no push; the store is accepted in the first cycle after a pop makes count<DEPTH.
REQ-020 Load hazard: a valid entry has addr[ADDR_SIZE-1:2] equal to core_addr[ADDR_SIZE-1:2]; the load stalls without issuing until no entry matches.
REQ-021 Load FSM states are IDLE, LREQ and LRESP; IDLE->LREQ on a hazard-free load; LREQ->LRESP on mem_gnt; LRESP->IDLE on mem_rvalid.
REQ-022 In LREQ: mem_req=1, mem_we=0, mem_addr=core_addr, mem_be=core_amp; loads take priority over drain.
REQ-023 core_stall=1 for every load cycle except the mem_rvalid cycle; core_rdata=mem_rdata in that cycle.
REQ-024 A hazard-free load with mem_gnt in the first cycle and mem_rvalid the next completes in 2 cycles.
REQ-025 Drain: when the FSM is IDLE, or in LRESP, and count>0 and no load issues: mem_req=1, mem_we=1, head entry on addr/be/wdata; pop on mem_gnt.
REQ-026 Request outputs stay stable while mem_req=1 and mem_gnt=0.
REQ-027 A push and a pop may occur in the same cycle; count is unchanged; pointers wrap modulo DEPTH.
REQ-028 core_fence: core_stall=1 while count>0; fence completes in the cycle count==0, which is immediate if already empty.
REQ-029 Stores drain in program order; each store is written exactly once.
REQ-030 mem_req=0 when the FIFO is empty and no load is pending.

Reset
REQ-031 With reset low at an edge: count=0, pointers=0, FSM=IDLE; outputs mem_req=0, core_stall=0, wbuf_empty=1, core_rdata=0.
REQ-032 Reset mid-operation discards buffered stores and any outstanding load; a mem_rvalid arriving after reset is ignored.

Structure
REQ-033 XLEN, ADDR_SIZE and the FSM state encoding belong in the shared xgriscv_defines file.
REQ-034 The FIFO is one sub-module, xgriscv_sbuf_fifo, with push/pop/full/empty and a per-entry match output.

Verification
REQ-035 Stores to 0x100, 0x104, 0x108 on consecutive cycles with mem_gnt=1 -> no stall; three writes in order; count 0 after 3 grants.
REQ-036 mem_gnt held 0 with five stores -> stall on the 5th store; count=4; the 5th store is accepted one cycle after the first grant.
REQ-037 Store 0xDEADBEEF to 0x200 with gnt held low, then load 0x202 -> stall until the store drains; the load then issues and returns mem_rdata.
REQ-038 Load 0x300 with empty FIFO, gnt in cycle 1, rvalid in cycle 2 -> core_stall=1,0; core_rdata=mem_rdata in cycle 2.
REQ-039 Two stores buffered, then core_fence -> stall exactly until count==0; fence with an empty FIFO -> no stall.
REQ-040 reset low with 3 entries buffered -> count=0, mem_req=0 next cycle; the previous head is never written.
